// File: rtl/bcd_adder_pkg.sv
// ---------------------------------------------------------------------------
// bcd_adder_pkg
// Shared constants and types for the registered BCD (8421) adder.
//   BCD_DIGIT_W    : bits per decimal digit
//   BCD_MAX_DIGIT  : largest legal BCD digit value
//   BCD_CORRECTION : value added to a digit whose binary sum exceeds 9
//   bcd_digit_t    : one packed BCD digit
//   digit_invalid(): true when a 4-bit digit is outside 0..9
// ---------------------------------------------------------------------------
package bcd_adder_pkg;

    localparam int         BCD_DIGIT_W    = 4;
    localparam logic [3:0] BCD_MAX_DIGIT  = 4'd9;
    localparam logic [3:0] BCD_CORRECTION = 4'd6;

    typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

    function automatic logic digit_invalid(input bcd_digit_t d);
        return (d > BCD_MAX_DIGIT);
    endfunction

endpackage

// File: rtl/bcd_adder_if.sv
// ---------------------------------------------------------------------------
// bcd_adder_if
// Operand / result bundle for bcd_adder.
//   in_valid, A, B, Cin        : driven by the master (operand source)
//   out_valid, bcdS, bcdCout   : driven by the slave (the adder)
//   digit_err                  : slave output, present only when
//                                BCD_ADDER_DIGIT_ERR_EN is defined
// Parameter NUM_DIGITS must match the NUM_DIGITS of the attached adder.
// ---------------------------------------------------------------------------
interface bcd_adder_if #(
    parameter int NUM_DIGITS = 1
);
    localparam int W = 4 * NUM_DIGITS;

    logic         in_valid;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         out_valid;
    logic [W-1:0] bcdS;
    logic         bcdCout;
`ifdef BCD_ADDER_DIGIT_ERR_EN
    logic         digit_err;

    modport master (
        output in_valid, A, B, Cin,
        input  out_valid, bcdS, bcdCout, digit_err
    );

    modport slave (
        input  in_valid, A, B, Cin,
        output out_valid, bcdS, bcdCout, digit_err
    );
`else
    modport master (
        output in_valid, A, B, Cin,
        input  out_valid, bcdS, bcdCout
    );

    modport slave (
        input  in_valid, A, B, Cin,
        output out_valid, bcdS, bcdCout
    );
`endif

endinterface

// File: rtl/bcd_digit_add.sv
// ---------------------------------------------------------------------------
// bcd_digit_add
// Purely combinational single-digit BCD adder.
//   a, b : operand digits (values 10..15 are accepted and run through the
//          same correction formula)
//   ci   : carry in
//   s    : corrected sum digit
//   co   : decimal carry out (binary sum > 9)
// ---------------------------------------------------------------------------
module bcd_digit_add
    import bcd_adder_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       ci,
    output bcd_digit_t s,
    output logic       co
);

    logic [4:0] z;
    logic       k;

    always_comb begin
        z  = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
        // z > 9 without a magnitude comparator: overflow past 15, or 8 plus 4/2
        k  = z[4] | (z[3] & z[2]) | (z[3] & z[1]);
        // Upper bit of the correction intentionally drops out (mod 16)
        s  = z[3:0] + (k ? BCD_CORRECTION : 4'd0);
        co = k;
    end

endmodule

// File: rtl/bcd_adder.sv
// ---------------------------------------------------------------------------
// bcd_adder
// Registered ripple-carry BCD adder, one cycle latency, one add per cycle.
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset, wins over bus.in_valid
//   bus    : bcd_adder_if.slave
//            in_valid/A/B/Cin in, out_valid/bcdS/bcdCout out (registered)
// Parameter NUM_DIGITS (1..8): digits per operand, digit 0 in bits [3:0].
// Optional macro BCD_ADDER_DIGIT_ERR_EN adds the registered bus.digit_err
// flag, set when an accepted operand has any digit above 9.
// ---------------------------------------------------------------------------
module bcd_adder
    import bcd_adder_pkg::*;
#(
    parameter int NUM_DIGITS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    bcd_adder_if.slave  bus
);

    localparam int W = BCD_DIGIT_W * NUM_DIGITS;

    logic [NUM_DIGITS:0] carry;
    logic [W-1:0]        sum_c;

    logic         out_valid_d, out_valid_q;
    logic [W-1:0] bcd_s_d,     bcd_s_q;
    logic         bcd_cout_d,  bcd_cout_q;

    assign carry[0] = bus.Cin;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit_add u_digit (
            .a  (bus.A[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .b  (bus.B[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .ci (carry[i]),
            .s  (sum_c[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .co (carry[i+1])
        );
    end

    always_comb begin
        out_valid_d = bus.in_valid;
        bcd_s_d     = bcd_s_q;
        bcd_cout_d  = bcd_cout_q;
        if (bus.in_valid) begin
            bcd_s_d    = sum_c;
            bcd_cout_d = carry[NUM_DIGITS];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            bcd_s_q     <= '0;
            bcd_cout_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            bcd_s_q     <= bcd_s_d;
            bcd_cout_q  <= bcd_cout_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.bcdS      = bcd_s_q;
    assign bus.bcdCout   = bcd_cout_q;

`ifdef BCD_ADDER_DIGIT_ERR_EN
    logic digit_err_d, digit_err_q;
    logic any_bad;

    always_comb begin
        any_bad = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            any_bad = any_bad
                    | digit_invalid(bus.A[i*BCD_DIGIT_W +: BCD_DIGIT_W])
                    | digit_invalid(bus.B[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
        end
        digit_err_d = bus.in_valid ? any_bad : digit_err_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit_err_q <= 1'b0;
        end else begin
            digit_err_q <= digit_err_d;
        end
    end

    assign bus.digit_err = digit_err_q;
`endif

endmodule

// File: tb/tb_bcd_adder.sv
// ---------------------------------------------------------------------------
// tb_bcd_adder
// Drives a 1-digit and a 2-digit bcd_adder with the same stimulus (the
// 1-digit instance sees the low nibble). Expected results are queued when
// an operand is accepted and compared one cycle later.
// ---------------------------------------------------------------------------
module tb_bcd_adder;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    bcd_adder_if #(.NUM_DIGITS(1)) if1 ();
    bcd_adder_if #(.NUM_DIGITS(2)) if2 ();

    bcd_adder #(.NUM_DIGITS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    bcd_adder #(.NUM_DIGITS(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

    typedef struct packed {
        logic [3:0] s1;
        logic       c1;
        logic       e1;
        logic [7:0] s2;
        logic       c2;
        logic       e2;
    } exp_t;

    typedef struct {
        string      name;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        exp_t       e;
    } vec_t;

    exp_t sb[$];
    exp_t hold;
    vec_t tbl[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference: digit-wise decimal add, correcting any digit sum above 9
    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic cin, input int nd);
        logic [7:0] s;
        logic       c;
        int         z;
        s = '0;
        c = cin;
        for (int i = 0; i < nd; i++) begin
            z = int'(a[4*i +: 4]) + int'(b[4*i +: 4]) + int'(c);
            if (z > 9) begin
                s[4*i +: 4] = 4'(z + 6);
                c = 1'b1;
            end else begin
                s[4*i +: 4] = 4'(z);
                c = 1'b0;
            end
        end
        return {c, s};
    endfunction

    function automatic logic bad_digits(input logic [7:0] a, input logic [7:0] b, input int nd);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < nd; i++)
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad = 1'b1;
        return bad;
    endfunction

    function automatic exp_t model_exp(input logic [7:0] a, input logic [7:0] b, input logic cin);
        exp_t       e;
        logic [8:0] r1, r2;
        r1   = model({4'h0, a[3:0]}, {4'h0, b[3:0]}, cin, 1);
        r2   = model(a, b, cin, 2);
        e.s1 = r1[3:0];
        e.c1 = r1[8];
        e.e1 = bad_digits({4'h0, a[3:0]}, {4'h0, b[3:0]}, 1);
        e.s2 = r2[7:0];
        e.c2 = r2[8];
        e.e2 = bad_digits(a, b, 2);
        return e;
    endfunction

    task automatic add_vec(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic [3:0] s1, input logic c1,
                           input logic [7:0] s2, input logic c2, input logic e1, input logic e2);
        vec_t v;
        v.name = name;
        v.a    = a;
        v.b    = b;
        v.cin  = cin;
        v.e    = '{s1: s1, c1: c1, e1: e1, s2: s2, c2: c2, e2: e2};
        tbl.push_back(v);
    endtask

    // One clock: drive, queue the expectation if accepted, check after the edge
    task automatic cycle(input string tag, input logic v, input logic [7:0] a,
                         input logic [7:0] b, input logic cin, input exp_t e);
        logic accepted;
        if1.in_valid = v;
        if1.A        = a[3:0];
        if1.B        = b[3:0];
        if1.Cin      = cin;
        if2.in_valid = v;
        if2.A        = a;
        if2.B        = b;
        if2.Cin      = cin;
        accepted     = v && rst_n;
        if (accepted) sb.push_back(e);
        @(posedge clk);
        #1;
        chk({tag, " out_valid1"}, 32'(if1.out_valid), 32'(accepted));
        chk({tag, " out_valid2"}, 32'(if2.out_valid), 32'(accepted));
        if (accepted) hold = sb.pop_front();
        if (!rst_n) begin
            hold = '0;
            sb.delete();
        end
        chk({tag, " bcdS1"},    32'(if1.bcdS),    32'(hold.s1));
        chk({tag, " bcdCout1"}, 32'(if1.bcdCout), 32'(hold.c1));
        chk({tag, " bcdS2"},    32'(if2.bcdS),    32'(hold.s2));
        chk({tag, " bcdCout2"}, 32'(if2.bcdCout), 32'(hold.c2));
`ifdef BCD_ADDER_DIGIT_ERR_EN
        chk({tag, " digit_err1"}, 32'(if1.digit_err), 32'(hold.e1));
        chk({tag, " digit_err2"}, 32'(if2.digit_err), 32'(hold.e2));
`endif
    endtask

    initial begin
        exp_t none;
        none = '0;
        hold = '0;

        //      name         a      b      cin  s1    c1  s2     c2  e1 e2
        add_vec("add_3_4",   8'h03, 8'h04, 0, 4'h7, 0, 8'h07, 0, 0, 0);
        add_vec("add_4_5",   8'h04, 8'h05, 0, 4'h9, 0, 8'h09, 0, 0, 0);
        add_vec("add_5_5",   8'h05, 8'h05, 0, 4'h0, 1, 8'h10, 0, 0, 0);
        add_vec("add_9_9_1", 8'h09, 8'h09, 1, 4'h9, 1, 8'h19, 0, 0, 0);
        add_vec("add_9_0_1", 8'h09, 8'h00, 1, 4'h0, 1, 8'h10, 0, 0, 0);
        add_vec("add_F_F_1", 8'h0F, 8'h0F, 1, 4'h5, 1, 8'h15, 0, 1, 1);
        add_vec("add_A_0",   8'h0A, 8'h00, 0, 4'h0, 1, 8'h10, 0, 1, 1);
        add_vec("add_99_01", 8'h99, 8'h01, 0, 4'h0, 1, 8'h00, 1, 0, 0);
        add_vec("add_45_38", 8'h45, 8'h38, 1, 4'h4, 1, 8'h84, 0, 0, 0);
        add_vec("add_C_1",   8'h0C, 8'h01, 0, 4'h3, 1, 8'h13, 0, 1, 1);
        add_vec("add_2_1",   8'h02, 8'h01, 0, 4'h3, 0, 8'h03, 0, 0, 0);
        add_vec("add_99_99", 8'h99, 8'h99, 1, 4'h9, 1, 8'h99, 1, 0, 0);

        // Reset held with valid operands present: nothing may be captured
        rst_n = 1'b0;
        cycle("reset0", 1'b1, 8'h09, 8'h09, 1'b0, none);
        cycle("reset1", 1'b1, 8'h09, 8'h09, 1'b0, none);
        rst_n = 1'b1;

        foreach (tbl[i])
            cycle(tbl[i].name, 1'b1, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].e);

        // Idle with wiggling operands: outputs hold the last result
        for (int i = 0; i < 3; i++)
            cycle("hold", 1'b0, 8'($urandom), 8'($urandom), 1'($urandom), none);

        // Reset mid-stream beats a valid operand, then restart
        rst_n = 1'b0;
        cycle("rst_vs_valid", 1'b1, 8'h99, 8'h99, 1'b1, none);
        rst_n = 1'b1;
        cycle("post_rst_idle", 1'b0, 8'h12, 8'h34, 1'b0, none);
        add_vec("restart", 8'h03, 8'h04, 0, 4'h7, 0, 8'h07, 0, 0, 0);
        cycle(tbl[$].name, 1'b1, tbl[$].a, tbl[$].b, tbl[$].cin, tbl[$].e);

        // Back-to-back sweep of every 4-bit A, B and Cin
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    logic [7:0] av, bv;
                    av = {4'(b), 4'(a)};
                    bv = {4'(a), 4'(b)};
                    cycle("sweep", 1'b1, av, bv, 1'(c), model_exp(av, bv, 1'(c)));
                end
            end
        end
        cycle("drain", 1'b0, 8'h00, 8'h00, 1'b0, none);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_adder.md
Name: bcd_adder

Overview:
- Registered, parameterisable ripple-carry BCD (8421) adder: adds two packed BCD operands plus a carry-in and produces a BCD-corrected sum and decimal carry-out.
- Sits in datapath arithmetic as a leaf block.
- One clock cycle of latency, with a valid pipeline flag.
- Default configuration is a single decimal digit (4-bit operands).

Parameters:
- NUM_DIGITS, 1, number of BCD digits per operand; operand width is 4*NUM_DIGITS; legal range 1..8.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- in_valid  input  1  operands valid this cycle.
- A  input  4*NUM_DIGITS  operand A, packed BCD, digit 0 in bits [3:0].
- B  input  4*NUM_DIGITS  operand B, packed BCD, same layout.
- Cin  input  1  carry-in into digit 0.
- out_valid  output  1  registered; high one cycle after an accepted in_valid.
- bcdS  output  4*NUM_DIGITS  registered BCD sum.
- bcdCout  output  1  registered decimal carry-out of the most significant digit.

Behaviour:
- Reset: on a rising clk with rst_n=0, set bcdS=0, bcdCout=0, out_valid=0. Reset has priority over in_valid.
- Per digit i (combinational):
  - Z = A_i + B_i + c_i, 5-bit binary, where c_0 = Cin and c_(i+1) = carry-out of digit i.
  - Digit carry K = Z[4] | (Z[3] & Z[2]) | (Z[3] & Z[1]), i.e. Z > 9.
  - S_i = (Z[3:0] + {0,K,K,0}) mod 16, i.e. add 6 when K=1.
- Ripple: the carry-out K of digit i feeds digit i+1. bcdCout = K of the top digit.
- Register update on each rising clk with rst_n=1:
  - out_valid <= in_valid.
  - When in_valid=1: bcdS <= combinational sum, bcdCout <= top carry.
  - When in_valid=0: bcdS and bcdCout hold their previous values.
- Latency: exactly 1 cycle. Throughput: one addition per cycle, no back-pressure.
- Non-BCD input digits (values 10..15) are not rejected. The same formula is applied deterministically.
  - Example: A=F, B=F, Cin=1 gives Z=31, S=5, Cout=1.
  - Example: A=A, B=0, Cin=0 gives S=0, Cout=1.
- Simultaneous reset and in_valid: reset wins; the operands are dropped.
- Reset deasserted mid-stream: first out_valid appears one cycle after the first sampled in_valid with rst_n=1.
- Outputs are never combinationally dependent on inputs.

Optional Feature:
- Macro: BCD_ADDER_DIGIT_ERR_EN.
- When defined:
  - Adds output port digit_err (1 bit, registered).
  - digit_err is set when in_valid=1 and any digit of A or B exceeds 9; it updates with the same timing as bcdS.
  - digit_err resets to 0 and holds when in_valid=0.
  - The sum is still computed per the formula.
- When undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Package bcd_adder_pkg holds:
  - BCD_DIGIT_W = 4
  - BCD_MAX_DIGIT = 4'd9
  - BCD_CORRECTION = 4'd6
  - typedef bcd_digit_t (logic [3:0])
- Sub-module bcd_digit_add: purely combinational single-digit adder.
  - Inputs: a, b (bcd_digit_t), ci.
  - Outputs: s (bcd_digit_t), co.
  - Top level instantiates it NUM_DIGITS times in a generate loop and registers the results.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, A=9, B=9 -> bcdS=0, bcdCout=0, out_valid=0 throughout.
- No correction (NUM_DIGITS=1): A=3, B=4, Cin=0, in_valid=1 -> next cycle bcdS=7, bcdCout=0, out_valid=1. Then A=4, B=5, Cin=0 -> bcdS=9, bcdCout=0.
- Correction boundary: A=5, B=5, Cin=0 -> bcdS=0, bcdCout=1. A=9, B=9, Cin=1 -> bcdS=9, bcdCout=1. A=9, B=0, Cin=1 -> bcdS=0, bcdCout=1.
- Exhaustive sweep (NUM_DIGITS=1): all 512 combinations of A, B (0..15) and Cin, back-to-back -> each result matches the formula one cycle later; spot-check F+F+1 -> S=5, Cout=1.
- Hold and ripple:
  - in_valid=0 with changing inputs -> bcdS and bcdCout unchanged, out_valid=0.
  - NUM_DIGITS=2: A=0x99, B=0x01, Cin=0 -> bcdS=0x00, bcdCout=1.
  - NUM_DIGITS=2: A=0x45, B=0x38, Cin=1 -> bcdS=0x84, bcdCout=0.
- Optional macro: with BCD_ADDER_DIGIT_ERR_EN, A=0xC, B=1 -> digit_err=1 and bcdS=3, bcdCout=1; A=2, B=1 -> digit_err=0.
